// File: rtl/ssd_codes_pkg.sv
// Shared 5-bit character codes for the lock display path, plus the
// active-low segment patterns and anode helpers used by the scan driver.
`timescale 1ns/1ps
package ssd_codes_pkg;

  // Character codes: 0x00-0x0F are hex digits, the rest are glyphs.
  localparam logic [4:0] CODE_HEX_0 = 5'h00;
  localparam logic [4:0] CODE_HEX_F = 5'h0F;
  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_TIRE  = 5'h11;
  localparam logic [4:0] CODE_L     = 5'h12;
  localparam logic [4:0] CODE_P     = 5'h13;
  localparam logic [4:0] CODE_O     = 5'h14;
  localparam logic [4:0] CODE_N     = 5'h15;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // All anodes released (active-low display).
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low anode pattern that lights exactly one digit.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ssd_code_to_seg.sv
// Combinational decoder: 5-bit character code to active-low seven-segment
// pattern. Unassigned codes fall through to blank.
`timescale 1ns/1ps
module ssd_code_to_seg
  import ssd_codes_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  // Look up the glyph for the selected character code.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves o_seg unassigned (no latch).
    o_seg = SEG_BLANK;
    case (i_code)
      5'h00:      o_seg = 7'b1000000;
      5'h01:      o_seg = 7'b1111001;
      5'h02:      o_seg = 7'b0100100;
      5'h03:      o_seg = 7'b0110000;
      5'h04:      o_seg = 7'b0011001;
      5'h05:      o_seg = 7'b0010010;
      5'h06:      o_seg = 7'b0000010;
      5'h07:      o_seg = 7'b1111000;
      5'h08:      o_seg = 7'b0000000;
      5'h09:      o_seg = 7'b0010000;
      5'h0A:      o_seg = 7'b0001000;
      5'h0B:      o_seg = 7'b0000011;
      5'h0C:      o_seg = 7'b1000110;
      5'h0D:      o_seg = 7'b0100001;
      5'h0E:      o_seg = 7'b0000110;
      5'h0F:      o_seg = 7'b0001110;
      CODE_BLANK: o_seg = SEG_BLANK;
      CODE_TIRE:  o_seg = 7'b0111111;
      CODE_L:     o_seg = 7'b1000111;
      CODE_P:     o_seg = 7'b0001100;
      CODE_O:     o_seg = 7'b0100011;
      CODE_N:     o_seg = 7'b0101011;
      default:    o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver. Captures a whole display word only at
// frame boundaries (no tearing), scans one digit per DIGIT_DIV cycles, and
// blanks masked digits during the off half of the blink period.
`timescale 1ns/1ps
module ssd_scan_driver
  import ssd_codes_pkg::*;
#(
  parameter int unsigned DIGIT_DIV  = 100000,
  parameter int unsigned BLINK_HALF = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd_in,
  input  logic [3:0]  blink_mask,
  input  logic        blink_restart,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DW = $clog2(DIGIT_DIV);
  localparam int BW = $clog2(BLINK_HALF);

  logic [DW-1:0]   r_digit_cnt;
  logic [1:0]      r_idx;
  logic [3:0][4:0] r_frame;
  logic            r_load_pending;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_off;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;

  logic            w_digit_tc;
  logic            w_frame_wrap;
  logic            w_blink_tc;
  logic            w_hide;
  logic [6:0]      w_glyph;

  assign w_digit_tc   = (r_digit_cnt == DW'(DIGIT_DIV - 1));
  assign w_frame_wrap = w_digit_tc && (r_idx == 2'd3);
  assign w_blink_tc   = (r_blink_cnt == BW'(BLINK_HALF - 1));
  assign w_hide       = r_blink_off && blink_mask[r_idx];

  ssd_code_to_seg u_dec (
    .i_code (r_frame[r_idx]),
    .o_seg  (w_glyph)
  );

  // Digit dwell counter and scan index; index wraps 3 -> 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit_cnt <= '0;
      r_idx       <= 2'd0;
    end else if (w_digit_tc) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_digit_cnt <= '0;
      r_idx       <= r_idx + 2'd1;
    end else begin
      r_digit_cnt <= r_digit_cnt + DW'(1);
    end
  end

  // Frame register: load once after reset, then only as the scan returns to digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the 20-bit frame is reset (to blanks) since it is a small register, not a RAM.
      r_frame        <= {4{CODE_BLANK}};
      r_load_pending <= 1'b1;
    end else if (r_load_pending || w_frame_wrap) begin
      r_frame        <= ssd_in;
      r_load_pending <= 1'b0;
    end
  end

  // Blink phase; a restart pulse forces the visible phase and wins over the toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (blink_restart) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_blink_tc) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Registered outputs; a hidden digit keeps its anode asserted but shows blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= an_select(r_idx);
      r_seg <= w_hide ? SEG_BLANK : w_glyph;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule
